// File: rtl/gearbox_20to16.sv
// 20-bit to 16-bit width converter over a 160-bit ring buffer.
// Bits flow LSB-first, and the read side is first-word-fall-through.
module gearbox_20to16 (
    input  logic        clk,
    input  logic        res_n,
    input  logic        shift_in,
    input  logic [19:0] data_in,
    output logic        full,
    output logic        valid_out,
    input  logic        shift_out,
    output logic [15:0] data_out
);

    logic [159:0] buffer;
    logic [2:0]   wr_idx;
    logic [3:0]   rd_idx;
    logic [7:0]   level;
    logic         wr_acc;
    logic         rd_acc;

    // 160 is a common multiple of 20 and 16, so both pointers wrap together at
    // the buffer edge and no slot ever straddles the wrap.
    assign full      = (level > 8'd140);
    assign valid_out = (level >= 8'd16);
    assign data_out  = buffer[16*rd_idx +: 16];

    assign wr_acc = shift_in && !full;
    assign rd_acc = shift_out && valid_out;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            buffer <= '0;
            wr_idx <= '0;
            rd_idx <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) begin
                buffer[20*wr_idx +: 20] <= data_in;
                wr_idx                  <= wr_idx + 3'd1;
            end
            if (rd_acc)
                rd_idx <= (rd_idx == 4'd9) ? 4'd0 : rd_idx + 4'd1;
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 8'd20;
                2'b01:   level <= level - 8'd16;
                2'b11:   level <= level + 8'd4;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_gearbox_20to16.sv
// Randomized bench for gearbox_20to16.
// The reference model is a queue of stream bits: writes push 20 bits and reads pop 16.
module tb_gearbox_20to16;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        shift_in = 1'b0;
    logic [19:0] data_in = '0;
    logic        full;
    logic        valid_out;
    logic        shift_out = 1'b0;
    logic [15:0] data_out;

    int vectors = 0;
    int errors  = 0;
    bit q[$];

    gearbox_20to16 dut (
        .clk       (clk),
        .res_n     (res_n),
        .shift_in  (shift_in),
        .data_in   (data_in),
        .full      (full),
        .valid_out (valid_out),
        .shift_out (shift_out),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic m_full();
        return q.size() > 140;
    endfunction

    function automatic logic m_valid();
        return q.size() >= 16;
    endfunction

    function automatic logic [15:0] m_data();
        logic [15:0] d = '0;
        for (int i = 0; i < 16 && i < q.size(); i++) d[i] = q[i];
        return d;
    endfunction

    // Drives one cycle starting at the negedge, updates the model at the
    // posedge, and returns at the following negedge.
    task automatic step(input logic si, input logic so, input logic [19:0] din);
        logic aw, ar;
        shift_in  = si;
        shift_out = so;
        data_in   = din;
        aw = si && !m_full();
        ar = so && m_valid();
        @(posedge clk);
        if (ar) for (int i = 0; i < 16; i++) void'(q.pop_front());
        if (aw) for (int i = 0; i < 20; i++) q.push_back(din[i]);
        @(negedge clk);
        shift_in  = 1'b0;
        shift_out = 1'b0;
    endtask

    task automatic do_reset();
        res_n = 1'b0;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        res_n = 1'b1;
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        q.delete();
        @(negedge clk);
        vectors++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        vectors++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
        vectors++; if (data_out !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", data_out); end
        res_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_reset();
        step(1'b1, 1'b0, 20'h12345);
        step(1'b1, 1'b0, 20'hABCDE);
        vectors++; if (valid_out !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", valid_out); end
        vectors++; if (data_out !== 16'h2345) begin errors++; $display("FAIL basic_w0 got %h want 2345", data_out); end
        step(1'b0, 1'b1, 20'h0);
        vectors++; if (data_out !== 16'hCDE1) begin errors++; $display("FAIL basic_w1 got %h want cde1", data_out); end
        step(1'b0, 1'b1, 20'h0);
        vectors++; if (valid_out !== 1'b0 || full !== 1'b0) begin
            errors++; $display("FAIL basic_empty got v=%b f=%b want v=0 f=0", valid_out, full); end
    endtask

    // With 8 bits remaining, a read must be ignored; the next write must continue the stream.
    task automatic test_empty_read();
        step(1'b0, 1'b1, 20'h0);
        step(1'b0, 1'b1, 20'h0);
        vectors++; if (valid_out !== 1'b0) begin errors++; $display("FAIL empty_valid got %b want 0", valid_out); end
        step(1'b1, 1'b0, 20'h5A5A5);
        vectors++; if (valid_out !== m_valid() || data_out !== m_data()) begin
            errors++; $display("FAIL empty_resume got v=%b d=%h want v=%b d=%h", valid_out, data_out, m_valid(), m_data()); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 20'($urandom));
        vectors++; if (full !== 1'b0) begin errors++; $display("FAIL fill7_full got %b want 0", full); end
        step(1'b1, 1'b0, 20'($urandom));
        vectors++; if (full !== 1'b1) begin errors++; $display("FAIL fill8_full got %b want 1", full); end
        step(1'b1, 1'b0, 20'($urandom));
        vectors++; if (full !== 1'b1 || data_out !== m_data()) begin
            errors++; $display("FAIL fill9_ignored got f=%b d=%h want f=1 d=%h", full, data_out, m_data()); end
        for (int i = 0; i < 10; i++) begin
            vectors++; if (valid_out !== 1'b1 || data_out !== m_data()) begin
                errors++; $display("FAIL drain_data[%0d] got v=%b d=%h want v=1 d=%h", i, valid_out, data_out, m_data()); end
            step(1'b0, 1'b1, 20'h0);
            vectors++; if (full !== m_full()) begin
                errors++; $display("FAIL drain_full[%0d] got %b want %b", i, full, m_full()); end
        end
        vectors++; if (valid_out !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", valid_out); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] cnt;
        do_reset();
        cnt = 20'($urandom);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, cnt);
            cnt = cnt + 20'd1;
            vectors++; if (valid_out !== m_valid() || full !== m_full() || (m_valid() && data_out !== m_data())) begin
                errors++; $display("FAIL b2b[%0d] got v=%b f=%b d=%h want v=%b f=%b d=%h",
                    i, valid_out, full, data_out, m_valid(), m_full(), m_data()); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 1'($urandom), 20'($urandom));
            vectors++; if (valid_out !== m_valid() || full !== m_full() || (m_valid() && data_out !== m_data())) begin
                errors++; $display("FAIL rand[%0d] got v=%b f=%b d=%h want v=%b f=%b d=%h",
                    i, valid_out, full, data_out, m_valid(), m_full(), m_data()); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 20'($urandom));
        vectors++; if (valid_out !== 1'b1) begin errors++; $display("FAIL pre_areset_valid got %b want 1", valid_out); end
        #2 res_n = 1'b0;
        q.delete();
        #1;
        vectors++; if (valid_out !== 1'b0 || full !== 1'b0 || data_out !== 16'h0000) begin
            errors++; $display("FAIL areset_now got v=%b f=%b d=%h want v=0 f=0 d=0000", valid_out, full, data_out); end
        @(negedge clk);
        res_n = 1'b1;
        step(1'b1, 1'b0, 20'hFFFFF);
        vectors++; if (valid_out !== 1'b1 || data_out !== 16'hFFFF) begin
            errors++; $display("FAIL areset_after got v=%b d=%h want v=1 d=ffff", valid_out, data_out); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_empty_read();
        test_fill_drain();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/gearbox_20to16.md
GEARBOX_20TO16 -- requirements
Module: gearbox_20to16

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 20-bit input, 16-bit output and 160-bit storage.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 res_n  input  1  asynchronous active-low reset.
REQ-005 shift_in  input  1  writer offers data_in this cycle.
REQ-006 data_in  input  20  input word.
REQ-007 full  output  1  high when fewer than 20 free bits remain; writes are refused.
REQ-008 valid_out  output  1  high when at least 16 bits are stored; doubles as the not-empty flag.
REQ-009 shift_out  input  1  reader consumes data_out this cycle.
REQ-010 data_out  output  16  oldest 16 stored bits, first-word-fall-through.

Function
REQ-011 Storage SHALL be a 160-bit ring buffer.
  - 8 write slots of 20 bits, indexed by wr_idx 0..7.
  - 10 read slots of 16 bits, indexed by rd_idx 0..9.
  - An 8-bit bit-count, level, ranging 0..160.
REQ-012 Bit order SHALL be LSB-first stream order.
  - Write slot k occupies buffer bits [20k+19:20k].
  - Read slot k occupies buffer bits [16k+15:16k].
  - The first input word lands in bits [19:0].
REQ-013 full SHALL equal (level > 140), decoded combinationally from registered level.
REQ-014 valid_out SHALL equal (level >= 16), decoded combinationally from registered level.
REQ-015 data_out SHALL equal buffer[16*rd_idx+15 : 16*rd_idx] combinationally; it is don't-care while valid_out=0.
REQ-016 An accepted write (shift_in && !full) SHALL:
  - store data_in into slot wr_idx;
  - advance wr_idx, wrapping 7->0;
  - add 20 to level.
REQ-017 An accepted read (shift_out && valid_out) SHALL:
  - advance rd_idx, wrapping 9->0;
  - subtract 16 from level.
REQ-018 shift_in while full=1 SHALL be ignored: no storage, pointer or level change, and no error indication.
REQ-019 shift_out while valid_out=0 SHALL be ignored: rd_idx and level unchanged.
REQ-020 Simultaneous accepted write and read in one cycle SHALL both take effect, with level += 4.
  - Acceptance is judged on pre-edge full/valid_out.
  - The read returns pre-edge data_out.
REQ-021 Latency: a word written at edge N SHALL make valid_out reflect the new level from edge N onward; no additional pipeline stage.
REQ-022 level SHALL never exceed 160 or drop below 0; the full/valid_out gating guarantees this.
REQ-023 Partial remainders (level 1..15) SHALL be retained indefinitely until further writes complete a 16-bit word.
REQ-024 Pointer wrap SHALL be seamless: read slot 9 (bits [159:144]) contains bits [159:144] of the stream regardless of write slot boundaries.

Reset
REQ-025 On res_n=0, level, wr_idx and rd_idx SHALL clear immediately without waiting for clk, and the buffer SHALL clear to all zeros.
REQ-026 During and after reset, full=0 and valid_out=0 SHALL hold; data_out=16'h0000 follows from the zeroed buffer.
REQ-027 Reset asserted mid-transfer SHALL discard all stored bits; the first write after res_n rises lands in slot 0.
REQ-028 Inputs sampled on the first posedge after res_n deasserts SHALL be honoured normally.

Verification
REQ-029 Basic: write 20'h12345 then 20'hABCDE.
  - Expect valid_out=1 with data_out=16'h2345.
  - Read -> data_out=16'hCDE1.
  - Read -> valid_out=0, level=8.
REQ-030 Fill: write 7 words, expect full=0 (level 140); write an 8th, expect full=1 (level 160).
  - A 9th write while full leaves wr_idx and level unchanged.
REQ-031 Drain from full: one read gives level 144, full=1; a second read gives level 128, full=0.
  - Ten reads total give level 0 and valid_out=0, with data matching the stream order.
REQ-032 Simultaneous: hold shift_in=shift_out=1 for 40 cycles with an incrementing input counter.
  - level rises by 4 per accepted pair.
  - Output words equal the 16-bit slices of the concatenated input stream across multiple wraps.
REQ-033 Empty read: shift_out=1 with level 8 -> no change to rd_idx or level.
REQ-034 Async reset: drop res_n between clk edges with level=100.
  - valid_out=0 and full=0 immediately.
  - After release, writing 20'hFFFFF yields data_out=16'hFFFF.
